// File: rtl/apb_requester.sv
// APB requester: turns a valid/ready command stream into APB SETUP/ACCESS transfers, one at a time.
// Optional ACCESS-phase timeout is compiled in when APB_REQUESTER_TIMEOUT_EN is defined.
module apb_requester #(
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned TimeoutCycles = 16
) (
   input  logic                   PCLK,
   input  logic                   reset,
   input  logic                   CmdValid,
   output logic                   CmdReady,
   input  logic                   CmdWrite,
   input  logic [AddrWidth-1:0]   CmdAddr,
   input  logic [DataWidth-1:0]   CmdWData,
   input  logic [DataWidth/8-1:0] CmdStrb,
   output logic                   RespValid,
   output logic [DataWidth-1:0]   RespRData,
   output logic                   RespErr,
   output logic                   PSEL,
   output logic                   PENABLE,
   output logic                   PWRITE,
   output logic [AddrWidth-1:0]   PADDR,
   output logic [DataWidth-1:0]   PWDATA,
   output logic [DataWidth/8-1:0] PSTRB,
   input  logic                   PREADY,
   input  logic [DataWidth-1:0]   PRDATA
);

   localparam int unsigned StrbWidth = DataWidth / 8;

   if ((TimeoutCycles < 2) || ((DataWidth % 8) != 0)) begin : g_param_check
      $error("apb_requester: invalid parameters");
   end

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

   state_e r_state, w_state_d;

   logic                 w_complete, w_timeout;
   logic                 w_load_cmd, w_load_rdata;
   logic                 w_psel_d, w_penable_d, w_cmd_ready_d, w_resp_valid_d;
   logic                 r_psel, r_penable, r_cmd_ready, r_resp_valid, r_pwrite;
   logic [AddrWidth-1:0] r_paddr;
   logic [DataWidth-1:0] r_pwdata, r_resp_rdata;
   logic [StrbWidth-1:0] r_pstrb;

   assign w_complete = (r_state == StAccess) && PREADY;

`ifdef APB_REQUESTER_TIMEOUT_EN
   localparam int unsigned CntWidth = $clog2(TimeoutCycles);

   logic [CntWidth-1:0] r_cnt;
   logic                r_resp_err;

   // Cleared while in SETUP so every ACCESS phase starts counting from zero.
   always_ff @(posedge PCLK or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (r_state == StSetup) begin
         r_cnt <= '0;
      end else if ((r_state == StAccess) && !PREADY) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign w_timeout = (r_state == StAccess) && !PREADY &&
                      (r_cnt == CntWidth'(TimeoutCycles - 1));

   always_ff @(posedge PCLK or negedge reset) begin
      if (!reset) begin
         r_resp_err <= 1'b0;
      end else begin
         r_resp_err <= w_timeout;
      end
   end

   assign RespErr = r_resp_err;
`else
   assign w_timeout = 1'b0;
   assign RespErr   = 1'b0;
`endif

   always_ff @(posedge PCLK or negedge reset) begin
      if (!reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:   if (CmdValid) w_state_d = StSetup;
         StSetup:  w_state_d = StAccess;
         StAccess: if (w_complete || w_timeout) w_state_d = StIdle;
         default:  w_state_d = StIdle;
      endcase
   end

   // Outputs are registered from the next state so they change cleanly on the edge.
   always_comb begin
      w_psel_d       = (w_state_d != StIdle);
      w_penable_d    = (w_state_d == StAccess);
      w_cmd_ready_d  = (w_state_d == StIdle);
      w_resp_valid_d = w_complete || w_timeout;
      w_load_cmd     = (r_state == StIdle) && CmdValid;
      w_load_rdata   = w_complete && !r_pwrite;
   end

   always_ff @(posedge PCLK or negedge reset) begin
      if (!reset) begin
         r_psel       <= 1'b0;
         r_penable    <= 1'b0;
         r_cmd_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_pwrite     <= 1'b0;
         r_paddr      <= '0;
         r_pwdata     <= '0;
         r_pstrb      <= '0;
         r_resp_rdata <= '0;
      end else begin
         r_psel       <= w_psel_d;
         r_penable    <= w_penable_d;
         r_cmd_ready  <= w_cmd_ready_d;
         r_resp_valid <= w_resp_valid_d;
         if (w_load_cmd) begin
            r_pwrite <= CmdWrite;
            r_paddr  <= CmdAddr;
            r_pwdata <= CmdWData;
            r_pstrb  <= CmdWrite ? CmdStrb : '0;
         end
         if (w_load_rdata) begin
            r_resp_rdata <= PRDATA;
         end
      end
   end

   assign CmdReady  = r_cmd_ready;
   assign RespValid = r_resp_valid;
   assign RespRData = r_resp_rdata;
   assign PSEL      = r_psel;
   assign PENABLE   = r_penable;
   assign PWRITE    = r_pwrite;
   assign PADDR     = r_paddr;
   assign PWDATA    = r_pwdata;
   assign PSTRB     = r_pstrb;

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: randomized commands and completer wait states
// checked against a transaction-level model of the APB protocol timing.
module tb_apb_requester;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned SW = DW / 8;
   localparam int unsigned TO = 4;

   logic          PCLK = 1'b0;
   logic          reset = 1'b0;
   logic          CmdValid = 1'b0;
   logic          CmdReady;
   logic          CmdWrite = 1'b0;
   logic [AW-1:0] CmdAddr = '0;
   logic [DW-1:0] CmdWData = '0;
   logic [SW-1:0] CmdStrb = '0;
   logic          RespValid;
   logic [DW-1:0] RespRData;
   logic          RespErr;
   logic          PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA;
   logic [SW-1:0] PSTRB;
   logic          PREADY = 1'b0;
   logic [DW-1:0] PRDATA = '0;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] m_rdata = '0;
   bit to_en;

   apb_requester #(
      .DataWidth    (DW),
      .AddrWidth    (AW),
      .TimeoutCycles(TO)
   ) dut (
      .PCLK     (PCLK),
      .reset    (reset),
      .CmdValid (CmdValid),
      .CmdReady (CmdReady),
      .CmdWrite (CmdWrite),
      .CmdAddr  (CmdAddr),
      .CmdWData (CmdWData),
      .CmdStrb  (CmdStrb),
      .RespValid(RespValid),
      .RespRData(RespRData),
      .RespErr  (RespErr),
      .PSEL     (PSEL),
      .PENABLE  (PENABLE),
      .PWRITE   (PWRITE),
      .PADDR    (PADDR),
      .PWDATA   (PWDATA),
      .PSTRB    (PSTRB),
      .PREADY   (PREADY),
      .PRDATA   (PRDATA)
   );

   always #5 PCLK = ~PCLK;

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   task automatic scramble_cmd();
      CmdValid = 1'($urandom);
      CmdWrite = 1'($urandom);
      CmdAddr  = $urandom;
      CmdWData = $urandom;
      CmdStrb  = 4'($urandom);
   endtask

   // One full transfer; the completer inserts 'waits' PREADY=0 cycles before PREADY=1.
   // Returns in the response cycle with CmdValid low.
   task automatic do_xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [SW-1:0] strb, input int waits,
                          input logic [DW-1:0] rdata, input string name);
      int guard;
      int k;
      bit done;
      bit exp_err;
      logic [AW+1+DW+SW-1:0] exp_fields;
      guard = 0;
      while (CmdReady !== 1'b1 && guard < 20) begin
         step();
         guard++;
      end
      checks++;
      if (CmdReady !== 1'b1) begin
         errors++;
         $display("FAIL %s_ready: CmdReady=%b required 1", name, CmdReady);
      end
      CmdValid = 1'b1;
      CmdWrite = wr;
      CmdAddr  = addr;
      CmdWData = wdata;
      CmdStrb  = strb;
      PREADY   = 1'($urandom);
      PRDATA   = $urandom;
      step();
      exp_fields = {addr, wr, wdata, wr ? strb : 4'h0};
      scramble_cmd();
      checks++;
      if ({PSEL, PENABLE, CmdReady, RespValid} !== 4'b1000 ||
          {PADDR, PWRITE, PWDATA, PSTRB} !== exp_fields) begin
         errors++;
         $display("FAIL %s_setup: ctl=%b fields=%h required ctl=1000 fields=%h", name,
                  {PSEL, PENABLE, CmdReady, RespValid}, {PADDR, PWRITE, PWDATA, PSTRB},
                  exp_fields);
      end
      PREADY = 1'($urandom);
      PRDATA = $urandom;
      step();
      k = 0;
      done = 1'b0;
      exp_err = 1'b0;
      while (!done) begin
         checks++;
         if ({PSEL, PENABLE, CmdReady, RespValid} !== 4'b1100 ||
             {PADDR, PWRITE, PWDATA, PSTRB} !== exp_fields) begin
            errors++;
            $display("FAIL %s_access%0d: ctl=%b fields=%h required ctl=1100 fields=%h", name, k,
                     {PSEL, PENABLE, CmdReady, RespValid}, {PADDR, PWRITE, PWDATA, PSTRB},
                     exp_fields);
         end
         if (k == waits) begin
            PREADY = 1'b1;
            PRDATA = rdata;
            done = 1'b1;
            if (!wr) m_rdata = rdata;
         end else begin
            PREADY = 1'b0;
            PRDATA = $urandom;
            if (to_en && k == TO - 1) begin
               done = 1'b1;
               exp_err = 1'b1;
            end
         end
         if (done) CmdValid = 1'b0;
         else scramble_cmd();
         step();
         k++;
      end
      checks++;
      if ({RespValid, RespErr, PSEL, PENABLE, CmdReady} !== {1'b1, exp_err, 3'b001} ||
          RespRData !== m_rdata) begin
         errors++;
         $display("FAIL %s_resp: v/e/sel/en/rdy=%b rdata=%h required %b rdata=%h", name,
                  {RespValid, RespErr, PSEL, PENABLE, CmdReady}, RespRData,
                  {1'b1, exp_err, 3'b001}, m_rdata);
      end
      PREADY = 1'($urandom);
      CmdValid = 1'b0;
   endtask

   task automatic check_idle(input string name);
      checks++;
      if ({RespValid, PSEL, PENABLE, CmdReady} !== 4'b0001) begin
         errors++;
         $display("FAIL %s_idle: v/sel/en/rdy=%b required 0001", name,
                  {RespValid, PSEL, PENABLE, CmdReady});
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge PCLK);
      #1;
      checks++;
      if ({PSEL, PENABLE, PWRITE, RespValid, RespErr} !== 5'b0 || PADDR !== '0 ||
          PWDATA !== '0 || PSTRB !== '0 || RespRData !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ctl=%b addr=%h wdata=%h strb=%h rdata=%h required all 0",
                  {PSEL, PENABLE, PWRITE, RespValid, RespErr}, PADDR, PWDATA, PSTRB, RespRData);
      end
      #3 reset = 1'b1;
      step();
      check_idle("reset_release");
   endtask

   task automatic test_write();
      do_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'b0101, 0, $urandom, "write");
      step();
      check_idle("write_after");
   endtask

   task automatic test_read();
      do_xfer(1'b0, 32'h20, $urandom, 4'hF, 3, 32'h12345678, "read");
      step();
      check_idle("read_after");
   endtask

   task automatic test_back_to_back();
      do_xfer(1'b1, $urandom, $urandom, 4'($urandom), 1, $urandom, "b2b_first");
      checks++;
      if (CmdReady !== 1'b1 || RespValid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_overlap: rdy=%b valid=%b required 1 1", CmdReady, RespValid);
      end
      do_xfer(1'b0, 32'hA5A5_0040, $urandom, 4'hF, 0, $urandom, "b2b_second");
      step();
      check_idle("b2b_after");
   endtask

   task automatic test_random();
      for (int i = 0; i < 14; i++) begin
         do_xfer(1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(6, 0)),
                 $urandom, "random");
         repeat ($urandom_range(2, 0)) step();
      end
      step();
      check_idle("random_after");
   endtask

   task automatic test_wait_limit();
      // Stuck completer: times out only when the optional timeout is built in.
      do_xfer(1'b0, $urandom, $urandom, 4'hF, TO + 6, $urandom, "stuck");
      step();
      // Ready on the last permitted ACCESS cycle always completes normally.
      do_xfer(1'b0, $urandom, $urandom, 4'hF, TO - 1, $urandom, "edge_ready");
      step();
      check_idle("wait_after");
   endtask

   task automatic test_reset_mid();
      CmdValid = 1'b1;
      CmdWrite = 1'b1;
      CmdAddr  = $urandom;
      CmdWData = $urandom;
      CmdStrb  = 4'hF;
      step();
      CmdValid = 1'b0;
      PREADY = 1'b0;
      step();
      step();
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({PSEL, PENABLE, RespValid} !== 3'b000) begin
         errors++;
         $display("FAIL reset_mid_async: sel/en/valid=%b required 000",
                  {PSEL, PENABLE, RespValid});
      end
      PREADY = 1'b1;
      m_rdata = '0;
      step();
      step();
      #3 reset = 1'b1;
      step();
      checks++;
      if ({RespValid, PSEL, PENABLE} !== 3'b000 || RespRData !== '0) begin
         errors++;
         $display("FAIL reset_mid_noresp: valid/sel/en=%b rdata=%h required 000 0",
                  {RespValid, PSEL, PENABLE}, RespRData);
      end
      PREADY = 1'b0;
      do_xfer(1'b0, $urandom, $urandom, 4'hF, 2, $urandom, "after_reset");
      step();
      check_idle("after_reset_idle");
   endtask

   initial begin
`ifdef APB_REQUESTER_TIMEOUT_EN
      to_en = 1'b1;
`else
      to_en = 1'b0;
`endif
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_random();
      test_wait_limit();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1);
   end

endmodule
